// File: rtl/noc_flit_channel_demuxer_pkg.sv
// NoC configuration and flit types shared by the flit channel demuxer slice.
package noc_flit_channel_demuxer_pkg;

  localparam int FLIT_WIDTH = 16;

  typedef logic [FLIT_WIDTH-1:0] noc_flit_t;

  typedef struct packed {
    int virtual_channels;
    int router_ports;
  } noc_config_t;

  localparam noc_config_t NOC_DEFAULT_CONFIG = '{virtual_channels: 32'sd2, router_ports: 32'sd5};

endpackage

// File: rtl/noc_flit_channel_demuxer_checker.sv
// Protocol and stability assertions for the flit channel demuxer.
module noc_flit_channel_demuxer_checker #(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 16
) (
  input logic                                 clk,
  input logic                                 rst_n,
  input logic [CHANNELS-1:0]                  i_valid,
  input logic [CHANNELS-1:0]                  push,
  input logic [CHANNELS-1:0]                  full,
  input logic [CHANNELS-1:0]                  o_valid,
  input logic [CHANNELS-1:0]                  o_ready,
  input logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  o_flit
);

  a_valid_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(i_valid));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push[c] && full[c]));
    a_flit_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (o_valid[c] && !o_ready[c]) |=> $stable(o_flit[c]));
  end

endmodule

// File: rtl/noc_flit_channel_fifo.sv
// Single virtual-channel FIFO with explicit pointer wrap (any DEPTH >= 2).
module noc_flit_channel_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  assign o_full  = (count_r == CW'(DEPTH));
  assign o_empty = (count_r == {CW{1'b0}});
  // A full FIFO never accepts, even when it pops in the same cycle.
  assign push_s  = i_push & ~o_full;
  assign pop_s   = i_pop & ~o_empty;
  assign o_count = count_r;
  assign o_data  = o_empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Storage is not reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= i_data;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/noc_flit_channel_demuxer.sv
// Steers flits from the shared link into per-virtual-channel FIFOs with isolated ready.
module noc_flit_channel_demuxer
  import noc_flit_channel_demuxer_pkg::*;
#(
  parameter noc_config_t CONFIG = NOC_DEFAULT_CONFIG,
  parameter int DEPTH = 4,
  localparam int CHANNELS = CONFIG.virtual_channels,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [CHANNELS-1:0]                 i_valid,
  output logic [CHANNELS-1:0]                 i_ready,
  input  logic [FLIT_WIDTH-1:0]               i_flit,
  output logic [CHANNELS-1:0]                 o_valid,
  input  logic [CHANNELS-1:0]                 o_ready,
  output logic [CHANNELS-1:0][FLIT_WIDTH-1:0] o_flit,
  output logic [CHANNELS-1:0][CW-1:0]         o_count
);

  logic [CHANNELS-1:0] push_s;
  logic [CHANNELS-1:0] pop_s;
  logic [CHANNELS-1:0] full_s;
  logic [CHANNELS-1:0] empty_s;

  // Ready depends only on registered occupancy, never on o_ready.
  assign i_ready = ~full_s;
  assign o_valid = ~empty_s;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign push_s[c] = i_valid[c] & ~full_s[c];
    assign pop_s[c]  = ~empty_s[c] & o_ready[c];

    noc_flit_channel_fifo #(
      .WIDTH (FLIT_WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (push_s[c]),
      .i_data  (i_flit),
      .o_full  (full_s[c]),
      .o_empty (empty_s[c]),
      .i_pop   (pop_s[c]),
      .o_data  (o_flit[c]),
      .o_count (o_count[c])
    );
  end

  noc_flit_channel_demuxer_checker #(
    .CHANNELS   (CHANNELS),
    .FLIT_WIDTH (FLIT_WIDTH)
  ) u_checker (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .push    (push_s),
    .full    (full_s),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_flit  (o_flit)
  );

endmodule

// File: tb/tb_noc_flit_channel_demuxer.sv
// Randomized bench for the flit channel demuxer against a queue-based channel model.
module tb_noc_flit_channel_demuxer;
  import noc_flit_channel_demuxer_pkg::*;

  localparam int CH      = NOC_DEFAULT_CONFIG.virtual_channels;
  localparam int DEPTH_A = 4;
  localparam int DEPTH_B = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Index 0 drives the DEPTH=4 instance, index 1 the DEPTH=3 instance.
  logic [CH-1:0]                 in_valid  [2];
  logic [FLIT_WIDTH-1:0]         in_flit   [2];
  logic [CH-1:0]                 in_oready [2];
  logic [CH-1:0]                 obs_ready [2];
  logic [CH-1:0]                 obs_valid [2];
  logic [CH-1:0][FLIT_WIDTH-1:0] obs_flit  [2];
  logic [CH-1:0][2:0]            a_count;
  logic [CH-1:0][1:0]            b_count;

  logic [FLIT_WIDTH-1:0] mq [2*CH][$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_flit_channel_demuxer #(.DEPTH(DEPTH_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_valid(in_valid[0]), .i_ready(obs_ready[0]), .i_flit(in_flit[0]),
    .o_valid(obs_valid[0]), .o_ready(in_oready[0]), .o_flit(obs_flit[0]), .o_count(a_count));

  noc_flit_channel_demuxer #(.DEPTH(DEPTH_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_valid(in_valid[1]), .i_ready(obs_ready[1]), .i_flit(in_flit[1]),
    .o_valid(obs_valid[1]), .o_ready(in_oready[1]), .o_flit(obs_flit[1]), .o_count(b_count));

  function automatic int depth_of(int d);
    return (d == 0) ? DEPTH_A : DEPTH_B;
  endfunction

  function automatic int obs_count(int d, int c);
    return (d == 0) ? int'(a_count[c]) : int'(b_count[c]);
  endfunction

  // {valid, ready, count, head flit} as the model predicts it.
  function automatic logic [FLIT_WIDTH+9:0] exp_vec(int d, int c);
    int sz = mq[d*CH+c].size();
    logic [FLIT_WIDTH-1:0] head = (sz != 0) ? mq[d*CH+c][0] : {FLIT_WIDTH{1'b0}};
    return {sz != 0, sz != depth_of(d), 8'(sz), head};
  endfunction

  function automatic logic [FLIT_WIDTH+9:0] obs_vec(int d, int c);
    return {obs_valid[d][c], obs_ready[d][c], 8'(obs_count(d, c)), obs_flit[d][c]};
  endfunction

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = '0; in_flit[d] = '0; in_oready[d] = '0;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2*CH; i++) mq[i].delete();
  endtask

  // Advance one clock: decide accepts/pops from pre-edge model state, then apply them.
  task automatic tick();
    bit push [2][CH];
    bit pop  [2][CH];
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++) begin
        push[d][c] = in_valid[d][c] && (mq[d*CH+c].size() != depth_of(d));
        pop[d][c]  = in_oready[d][c] && (mq[d*CH+c].size() != 0);
      end
    @(posedge clk);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++) begin
        if (pop[d][c]) void'(mq[d*CH+c].pop_front());
        if (push[d][c]) mq[d*CH+c].push_back(in_flit[d]);
      end
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++) begin
        checks++;
        if (obs_vec(d, c) !== exp_vec(d, c)) begin
          errors++;
          $display("FAIL reset dut%0d ch%0d: got %h expected %h", d, c, obs_vec(d, c), exp_vec(d, c));
        end
      end
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++) begin
        checks++;
        if (obs_vec(d, c) !== exp_vec(d, c)) begin
          errors++;
          $display("FAIL idle dut%0d ch%0d: got %h expected %h", d, c, obs_vec(d, c), exp_vec(d, c));
        end
      end
  endtask

  task automatic test_single_flit();
    in_valid[0] = 2'b01;
    in_flit[0]  = 16'h00A5;
    tick();
    in_valid[0] = '0;
    checks++;
    if (obs_valid[0] !== 2'b01 || obs_flit[0][0] !== 16'h00A5 || obs_flit[0][1] !== 16'h0000) begin
      errors++;
      $display("FAIL single_flit: got valid %b flit0 %h flit1 %h expected 01 00a5 0000",
               obs_valid[0], obs_flit[0][0], obs_flit[0][1]);
    end
    in_oready[0] = '1;
    tick();
    in_oready[0] = '0;
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (obs_vec(0, c) !== exp_vec(0, c)) begin
        errors++;
        $display("FAIL single_drain ch%0d: got %h expected %h", c, obs_vec(0, c), exp_vec(0, c));
      end
    end
  endtask

  task automatic test_fill();
    int ch1_pushes = 0;
    // Alternate channels so each sees its FIFO fill; the ninth beat is a fifth push to ch1.
    for (int i = 0; i < 9; i++) begin
      int c = (i % 2 == 0) ? 1 : 0;
      in_valid[0] = '0;
      in_valid[0][c] = 1'b1;
      in_flit[0] = 16'($urandom);
      tick();
      for (int k = 0; k < CH; k++) begin
        checks++;
        if (obs_vec(0, k) !== exp_vec(0, k)) begin
          errors++;
          $display("FAIL fill beat%0d ch%0d: got %h expected %h", i, k, obs_vec(0, k), exp_vec(0, k));
        end
      end
    end
    in_valid[0] = '0;
    checks++;
    if (obs_ready[0] !== 2'b00 || a_count[1] !== 3'd4) begin
      errors++;
      $display("FAIL fill_full: got ready %b count1 %0d expected 00 4", obs_ready[0], a_count[1]);
    end
    in_oready[0] = '1;
    for (int i = 0; i < 5; i++) begin
      tick();
      for (int k = 0; k < CH; k++) begin
        checks++;
        if (obs_vec(0, k) !== exp_vec(0, k)) begin
          errors++;
          $display("FAIL drain beat%0d ch%0d: got %h expected %h", i, k, obs_vec(0, k), exp_vec(0, k));
        end
      end
    end
    in_oready[0] = '0;
  endtask

  task automatic test_full_pop_push();
    in_valid[0] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      in_flit[0] = 16'($urandom);
      tick();
    end
    in_oready[0] = 2'b10;
    in_flit[0] = 16'hBEEF;
    tick();
    in_valid[0] = '0;
    in_oready[0] = '0;
    checks++;
    if (a_count[1] !== 3'd3 || obs_ready[0][1] !== 1'b1 || obs_vec(0, 1) !== exp_vec(0, 1)) begin
      errors++;
      $display("FAIL full_pop_push: got %h expected %h", obs_vec(0, 1), exp_vec(0, 1));
    end
    in_oready[0] = '1;
    repeat (4) tick();
    in_oready[0] = '0;
    checks++;
    if (obs_vec(0, 1) !== exp_vec(0, 1) || obs_valid[0] !== 2'b00) begin
      errors++;
      $display("FAIL full_pop_push_drain: got %h expected %h", obs_vec(0, 1), exp_vec(0, 1));
    end
  endtask

  task automatic test_wrap();
    in_valid[1] = 2'b01;
    in_flit[1] = 16'($urandom);
    tick();
    in_oready[1] = 2'b01;
    for (int i = 0; i < 20; i++) begin
      in_flit[1] = 16'($urandom);
      tick();
      checks++;
      if (obs_vec(1, 0) !== exp_vec(1, 0) || b_count[0] !== 2'd1) begin
        errors++;
        $display("FAIL wrap beat%0d: got %h expected %h", i, obs_vec(1, 0), exp_vec(1, 0));
      end
    end
    in_valid[1] = '0;
    tick();
    in_oready[1] = '0;
    checks++;
    if (obs_valid[1] !== 2'b00) begin
      errors++;
      $display("FAIL wrap_drain: got valid %b expected 00", obs_valid[1]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        int idx = int'($urandom_range(0, CH));
        in_valid[d] = '0;
        if (idx < CH) in_valid[d][idx] = 1'b1;
        in_flit[d] = 16'($urandom);
        in_oready[d] = CH'($urandom);
      end
      tick();
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < CH; c++) begin
          checks++;
          if (obs_vec(d, c) !== exp_vec(d, c)) begin
            errors++;
            $display("FAIL random beat%0d dut%0d ch%0d: got %h expected %h",
                     i, d, c, obs_vec(d, c), exp_vec(d, c));
          end
        end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    in_oready[0] = '1;
    repeat (4) tick();
    in_oready[0] = '0;
    in_valid[0] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      in_flit[0] = 16'hC000 + 16'(i);
      tick();
    end
    in_valid[0] = '0;
    checks++;
    if (obs_vec(0, 0) !== exp_vec(0, 0) || a_count[0] !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset: got %h expected %h", obs_vec(0, 0), exp_vec(0, 0));
    end
    #2 rst_n = 1'b0;
    clear_model();
    #1;
    checks++;
    if (obs_valid[0] !== 2'b00 || a_count !== '0 || obs_flit[0] !== '0 || obs_ready[0] !== 2'b11) begin
      errors++;
      $display("FAIL async_reset: got valid %b count %h flit %h ready %b expected 00 0 0 11",
               obs_valid[0], a_count, obs_flit[0], obs_ready[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_oready[0] = '1;
    for (int i = 0; i < 4; i++) begin
      tick();
      for (int c = 0; c < CH; c++) begin
        checks++;
        if (obs_vec(0, c) !== exp_vec(0, c)) begin
          errors++;
          $display("FAIL post_reset beat%0d ch%0d: got %h expected %h", i, c, obs_vec(0, c), exp_vec(0, c));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_flit();
    test_fill();
    test_full_pop_push();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_flit_channel_demuxer.md
Name: noc_flit_channel_demuxer

Overview:
Receive-side counterpart of the per-channel merger. It takes the single shared flit link (per-channel valid/ready) and steers each flit into a per-virtual-channel FIFO. It then presents each channel as an independent valid/ready/flit stream to the router input or arbitration logic. Per-channel ready is derived from FIFO space, so one blocked channel never stalls the others (head-of-line isolation).

Parameters:
CONFIG, NOC_DEFAULT_CONFIG, NoC configuration struct from noc_config_pkg
CHANNELS, CONFIG.virtual_channels (localparam), number of virtual channels
DEPTH, 4, FIFO entries per channel; legal range >= 2, not required to be a power of 2
FLIT_WIDTH, from noc_flit.svh (package constant), flit width in bits

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
i_valid  input  CHANNELS  shared link valid; at most one bit set per cycle
i_ready  output  CHANNELS  per-channel ready, 1 = channel FIFO not full
i_flit  input  FLIT_WIDTH  shared link flit
o_valid  output  CHANNELS  per-channel output valid (FIFO not empty)
o_ready  input  CHANNELS  per-channel output ready from consumer
o_flit  output  CHANNELS x FLIT_WIDTH  per-channel head flit
o_count  output  CHANNELS x $clog2(DEPTH+1)  per-channel occupancy, for debug/credit visibility

Behaviour:
- Reset (async, rst_n=0):
  - All FIFO counts = 0, read/write pointers = 0.
  - o_valid = 0, o_count = 0, i_ready = all 1s.
  - o_flit = 0; storage contents need not be reset, but o_flit is masked to 0 while o_valid = 0.
- Push: channel c is written when i_valid[c] & i_ready[c]. i_flit is written at the write pointer of channel c, which then advances.
- i_ready[c] = (count[c] != DEPTH), decoded from registered state only, with no combinational path from o_ready. A full FIFO refuses a push even while it pops in the same cycle (no pass-through).
- Pop: channel c pops when o_valid[c] & o_ready[c]; its read pointer advances.
- o_valid[c] = (count[c] != 0). o_flit[c] = entry at the read pointer.
- Latency: a flit accepted in cycle N appears on o_valid/o_flit in cycle N+1. There is no empty-FIFO bypass.
- Simultaneous push and pop on one channel: count unchanged, both pointers advance, FIFO order preserved.
- Pointer wrap: a pointer at DEPTH-1 returns to 0 explicitly, which supports non-power-of-2 depths.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- o_flit[c] stays stable while o_valid[c] & !o_ready[c].
- Multi-hot i_valid is a protocol violation and is flagged by a simulation assertion. The RTL still writes i_flit into every channel whose valid & ready bits are set; no extra guarding logic.
- Channels are fully independent, with no cross-channel arbitration in this block.
- Reset mid-operation: all buffered flits are discarded immediately, and outputs return to their reset values asynchronously.
- Assertions:
  - no push while full;
  - o_flit stable under backpressure;
  - $onehot0(i_valid).

Decomposition:
- FLIT_WIDTH and the noc_flit typedef come from noc_flit.svh / noc_config_pkg; CHANNELS comes from CONFIG.virtual_channels. Nothing new goes into the package.
- One natural sub-module, noc_flit_channel_fifo:
  - single-channel FIFO with parameters WIDTH and DEPTH;
  - ports i_push, i_data, o_full, o_empty, i_pop, o_data, o_count.
- The top level instantiates it CHANNELS times in a generate loop and adds the valid/ready decode.

Test Plan:
- Reset then idle: o_valid=0, i_ready=all 1s, o_count=0 on every channel.
- Single flit: i_valid=2'b01 with flit 0xA5 in cycle N -> o_valid[0]=1 and o_flit[0]=0xA5 in cycle N+1. Channel 1 unaffected.
- Fill channel 1 (DEPTH=4) with o_ready[1]=0: i_ready[1] drops after the 4th push and a 5th push is refused. Channel 0 keeps accepting 4 flits concurrently. Releasing o_ready[1] drains 4 flits in push order.
- Full FIFO with pop and push in the same cycle: the push is refused (i_ready=0), count goes 4->3, and i_ready rises the next cycle.
- Steady push and pop on one channel for 20 flits (DEPTH=3): pointers wrap, order preserved, count constant at 1, no drops.
- Assert rst_n with 3 flits buffered: o_valid drops to 0 asynchronously. After release, counts are 0 and the old flits are never emitted.
